// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run/step/run-N controller generating CPU and memory clock enables
// Optional breakpoint logic: define CORE_RUN_CTRL_BP_EN.
module core_run_ctrl #(
  parameter int DIV_LOG2 = 1,
  parameter int PC_W     = 32,
  parameter int NUM_BP   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [1:0]             mode,
  input  logic                   step,
  input  logic                   start,
  input  logic [CNT_W-1:0]       run_n,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_valid,
  output logic                   cpu_ce,
  output logic                   mem_ce,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [31:0]            cycle_cnt
);

  typedef enum logic [2:0] {
    S_STOP      = 3'd0,
    S_STEP_PEND = 3'd1,
    S_RUN       = 3'd2,
    S_BURST     = 3'd3,
    S_BRK       = 3'd4
  } state_t;

  localparam logic [DIV_LOG2-1:0] MEM_PH = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);

  state_t              state, state_n;
  logic [DIV_LOG2-1:0] ph;
  logic [CNT_W-1:0]    rem;
  logic                sync1, sync2, sync3;
  logic                step_rise, tick, bp_match, skip;
  logic                mode_step, mode_run, mode_runn;
  logic                load_rem, enter_brk, exit_brk;

  assign tick      = &ph;
  assign mem_ce    = (ph == MEM_PH);
  assign step_rise = sync2 & ~sync3;
  assign mode_run  = (mode == 2'b01);
  assign mode_runn = (mode == 2'b10);
  assign mode_step = ~mode_run & ~mode_runn;

`ifdef CORE_RUN_CTRL_BP_EN
  logic [NUM_BP-1:0] bp_eq;

  always_comb begin
    bp_eq = '0;
    for (int i = 0; i < NUM_BP; i++)
      bp_eq[i] = bp_valid[i] && (pc == bp_addr[i*PC_W +: PC_W]);
  end

  // skip lets the instruction sitting on the breakpoint PC execute once after resume
  assign bp_match = (|bp_eq) & ~skip;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      skip   <= 1'b0;
      bp_hit <= '0;
    end else begin
      if (exit_brk) begin
        skip   <= 1'b1;
        bp_hit <= '0;
      end else begin
        if (cpu_ce)
          skip <= 1'b0;
        if (enter_brk)
          bp_hit <= bp_hit | bp_eq;
      end
    end
  end
`else
  logic unused_bp;

  assign bp_match  = 1'b0;
  assign skip      = 1'b0;
  assign bp_hit    = '0;
  assign unused_bp = ^{pc, bp_addr, bp_valid, enter_brk, exit_brk, skip};
`endif

  assign cpu_ce = tick & ((((state == S_RUN) || (state == S_BURST)) & ~bp_match)
                          | (state == S_STEP_PEND));

  always_comb begin
    state_n   = state;
    load_rem  = 1'b0;
    enter_brk = 1'b0;
    exit_brk  = 1'b0;
    case (state)
      S_STOP: begin
        if (mode_step && step_rise)
          state_n = S_STEP_PEND;
        else if (mode_run && start)
          state_n = S_RUN;
        else if (mode_runn && start && (run_n != '0)) begin
          state_n  = S_BURST;
          load_rem = 1'b1;
        end
      end
      S_STEP_PEND: begin
        if (tick)
          state_n = S_STOP;
      end
      S_RUN: begin
        if (tick && bp_match) begin
          state_n   = S_BRK;
          enter_brk = 1'b1;
        end else if (!mode_run)
          state_n = S_STOP;
      end
      S_BURST: begin
        if (tick && bp_match) begin
          state_n   = S_BRK;
          enter_brk = 1'b1;
        end else if (cpu_ce && (rem == CNT_W'(1)))
          state_n = S_STOP;
        else if (!mode_runn)
          state_n = S_STOP;
      end
      S_BRK: begin
        if (mode_run && start) begin
          state_n  = S_RUN;
          exit_brk = 1'b1;
        end else if (mode_runn && start) begin
          exit_brk = 1'b1;
          if (run_n != '0) begin
            state_n  = S_BURST;
            load_rem = 1'b1;
          end else
            state_n = S_STOP;
        end else if (mode_step && step_rise) begin
          state_n  = S_STEP_PEND;
          exit_brk = 1'b1;
        end
      end
      default: state_n = S_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_STOP;
      ph        <= '0;
      rem       <= '0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      halted    <= 1'b1;
      cycle_cnt <= '0;
    end else begin
      state  <= state_n;
      ph     <= ph + DIV_LOG2'(1);
      sync1  <= step;
      sync2  <= sync1;
      sync3  <= sync2;
      halted <= (state_n == S_STOP) || (state_n == S_BRK);
      if (load_rem)
        rem <= run_n;
      else if (cpu_ce && (state == S_BURST))
        rem <= rem - CNT_W'(1);
      if (cpu_ce)
        cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - directed self-checking bench for core_run_ctrl (DIV_LOG2=1)
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [1:0]  mode;
  logic        step;
  logic        start;
  logic [15:0] run_n;
  logic [31:0] pc;
  logic [63:0] bp_addr;
  logic [1:0]  bp_valid;
  logic        cpu_ce, mem_ce, halted;
  logic [1:0]  bp_hit;
  logic [31:0] cycle_cnt;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int ce_log[$];
  logic ce_now;

  core_run_ctrl #(.DIV_LOG2(1), .PC_W(32), .NUM_BP(2), .CNT_W(16)) dut (
    .clk(clk), .aresetn(aresetn), .mode(mode), .step(step), .start(start),
    .run_n(run_n), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_ce(cpu_ce), .mem_ce(mem_ce), .halted(halted), .bp_hit(bp_hit),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: samples cpu_ce, lets one posedge commit it, advances the PC model.
  task automatic cyc();
    #1;
    ce_now = cpu_ce;
    if (ce_now) ce_log.push_back(cyc_n);
    @(posedge clk);
    #1;
    if (ce_now) pc = pc + 32'd4;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    aresetn  = 1'b0;
    mode     = 2'b00;
    step     = 1'b0;
    start    = 1'b0;
    run_n    = '0;
    pc       = '0;
    bp_addr  = {32'h0000_1000, 32'h0000_0010};
    bp_valid = 2'b00;

    // reset values
    #12;
    chk("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_mem_ce", {31'd0, mem_ce}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_bp_hit", {30'd0, bp_hit}, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);

    // release at a negedge: mem_ce on even clks, no cpu_ce in idle STEP mode
    @(negedge clk);
    aresetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      chk($sformatf("idle_mem_ce_%0d", k), {31'd0, mem_ce}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("idle_cpu_ce_%0d", k), {31'd0, cpu_ce}, 32'd0);
      @(negedge clk);
    end

    // STEP: two long presses -> two pulses
    ce_log.delete();
    step = 1'b1; cycles(40);
    step = 1'b0; cycles(20);
    step = 1'b1; cycles(40);
    step = 1'b0; cycles(10);
    chk("step_pulses", ce_log.size(), 32'd2);
    chk("step_cycle_cnt", cycle_cnt, 32'd2);
    chk("step_halted", {31'd0, halted}, 32'd1);

    // RUN_N of 5
    ce_log.delete();
    mode = 2'b10; run_n = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("burst_running", {31'd0, halted}, 32'd0);
    cycles(20);
    chk("burst_pulses", ce_log.size(), 32'd5);
    for (int i = 1; i < ce_log.size(); i++)
      chk($sformatf("burst_gap_%0d", i), ce_log[i] - ce_log[i-1], 32'd2);
    chk("burst_halted", {31'd0, halted}, 32'd1);
    chk("burst_cycle_cnt", cycle_cnt, 32'd7);

    // RUN_N with zero length is ignored
    ce_log.delete();
    run_n = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cycles(10);
    chk("zero_pulses", ce_log.size(), 32'd0);
    chk("zero_halted", {31'd0, halted}, 32'd1);

    // breakpoint at 0x10 in RUN mode
    ce_log.delete();
    pc = '0; bp_valid = 2'b01; mode = 2'b01; start = 1'b1;
    cyc();
    start = 1'b0;
    cycles(20);
`ifdef CORE_RUN_CTRL_BP_EN
    chk("bp_pulses", ce_log.size(), 32'd4);
    chk("bp_pc", pc, 32'h10);
    chk("bp_halted", {31'd0, halted}, 32'd1);
    chk("bp_hit", {30'd0, bp_hit}, 32'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 20 && pc < 32'h14; i++) cyc();
    chk("resume_pc", pc, 32'h14);
    chk("resume_bp_hit", {30'd0, bp_hit}, 32'd0);
`else
    chk("nobp_pulses", ce_log.size(), 32'd10);
    chk("nobp_pc", pc, 32'h28);
    chk("nobp_halted", {31'd0, halted}, 32'd0);
    chk("nobp_bp_hit", {30'd0, bp_hit}, 32'd0);
`endif
    mode = 2'b00;
    cycles(4);
    chk("run_stop_halted", {31'd0, halted}, 32'd1);

    // reset in the middle of a long burst
    ce_log.delete();
    bp_valid = 2'b00; mode = 2'b10; run_n = 16'd100; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 60 && ce_log.size() < 10; i++) cyc();
    chk("mid_pulses", ce_log.size(), 32'd10);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("mid_rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    aresetn = 1'b1;
    ce_log.delete();
    cycles(10);
    chk("post_rst_pulses", ce_log.size(), 32'd0);
    chk("post_rst_halted", {31'd0, halted}, 32'd1);
    chk("post_rst_cycle_cnt", cycle_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
